// File: rtl/servant_sleep_ctrl_if.sv
// Core-side sleep handshake and status bundle for servant_sleep_ctrl.
// The controller uses the slave modport; the core/testbench drives the master modport.
interface servant_sleep_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             i_sleep_req;
    logic             i_wakeup_req;
    logic             i_ext_irq;
    logic             i_wb_busy;
    logic             o_clk_en;
    logic             o_sleeping;
    logic             o_abort;
    logic [1:0]       o_wake_cause;
    logic [CNT_W-1:0] o_sleep_cnt;

    modport master (
        output i_sleep_req,
        output i_wakeup_req,
        output i_ext_irq,
        output i_wb_busy,
        input  o_clk_en,
        input  o_sleeping,
        input  o_abort,
        input  o_wake_cause,
        input  o_sleep_cnt
    );

    modport slave (
        input  i_sleep_req,
        input  i_wakeup_req,
        input  i_ext_irq,
        input  i_wb_busy,
        output o_clk_en,
        output o_sleeping,
        output o_abort,
        output o_wake_cause,
        output o_sleep_cnt
    );
endinterface

// File: rtl/servant_sleep_ctrl.sv
// Sleep/clock-gating sequencer: drains the bus, gates wb_clk, wakes on timer or external IRQ.
// Define SERVANT_SLEEP_CNT_EN to build the saturating sleep-duration counter; otherwise o_sleep_cnt is 0.
module servant_sleep_ctrl #(
    parameter int DRAIN_MAX  = 64,
    parameter int WAKE_DELAY = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    servant_sleep_ctrl_if.slave   sleep_bus
);

    localparam int DRAIN_W  = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam int WAKE_CYC = (WAKE_DELAY < 1) ? 1 : WAKE_DELAY;
    localparam int WAKE_W   = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
    localparam logic [WAKE_W-1:0]  WAKE_LAST  = WAKE_W'(WAKE_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sleep_prev;
    logic                 r_sleep_arm;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [WAKE_W-1:0]    r_wake_cnt;
    logic                 r_clk_en;
    logic                 r_sleeping;
    logic                 r_abort;
    logic [1:0]           r_wake_cause;
    logic [CNT_W-1:0]     w_sleep_cnt;

    logic                 w_wake;
    logic                 w_sleep_edge;
    logic                 w_abort_req;
    logic                 w_drain_clr;
    logic                 w_drain_inc;
    logic                 w_wake_clr;
    logic                 w_wake_inc;
    logic                 w_cause_clr;
    logic                 w_cause_load;
    logic                 w_run_nxt;

    assign w_wake = sleep_bus.i_wakeup_req | r_sync2;

    // r_sleep_arm stays low after a reset taken with the request already high,
    // so a level held through reset cannot masquerade as a fresh rising edge.
    assign w_sleep_edge = sleep_bus.i_sleep_req & ~r_sleep_prev & r_sleep_arm;

    always_comb begin
        w_state_nxt  = r_state;
        w_abort_req  = 1'b0;
        w_drain_clr  = 1'b0;
        w_drain_inc  = 1'b0;
        w_wake_clr   = 1'b0;
        w_wake_inc   = 1'b0;
        w_cause_clr  = 1'b0;
        w_cause_load = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_sleep_edge) begin
                    if (w_wake) begin
                        w_abort_req = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                        w_drain_clr = 1'b1;
                        w_cause_clr = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_wake) begin
                    w_state_nxt = ST_RUN;
                    w_abort_req = 1'b1;
                end else if (!sleep_bus.i_wb_busy) begin
                    w_state_nxt = ST_SLEEP;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_abort_req = 1'b1;
                end else begin
                    w_drain_inc = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (w_wake) begin
                    w_state_nxt  = ST_WAKE;
                    w_wake_clr   = 1'b1;
                    w_cause_load = 1'b1;
                end
            end
            ST_WAKE: begin
                if (r_wake_cnt == WAKE_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_wake_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sleep_prev <= 1'b0;
            r_sleep_arm  <= ~sleep_bus.i_sleep_req;
            r_drain_cnt  <= '0;
            r_wake_cnt   <= '0;
            r_clk_en     <= 1'b1;
            r_sleeping   <= 1'b0;
            r_abort      <= 1'b0;
            r_wake_cause <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_sync1      <= sleep_bus.i_ext_irq;
            r_sync2      <= r_sync1;
            r_sleep_prev <= sleep_bus.i_sleep_req;
            r_sleep_arm  <= r_sleep_arm | ~sleep_bus.i_sleep_req;
            // Status flags mirror the next state so they line up with r_state.
            r_clk_en     <= w_run_nxt;
            r_sleeping   <= ~w_run_nxt;
            r_abort      <= w_abort_req & ~r_abort;

            if (w_drain_clr) begin
                r_drain_cnt <= '0;
            end else if (w_drain_inc) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end

            if (w_wake_clr) begin
                r_wake_cnt <= '0;
            end else if (w_wake_inc) begin
                r_wake_cnt <= r_wake_cnt + 1'b1;
            end

            if (w_cause_clr) begin
                r_wake_cause <= 2'b00;
            end else if (w_cause_load) begin
                r_wake_cause <= {r_sync2, sleep_bus.i_wakeup_req};
            end
        end
    end

`ifdef SERVANT_SLEEP_CNT_EN
    logic [CNT_W-1:0] r_sleep_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sleep_cnt <= '0;
        end else if ((r_state == ST_DRAIN) && (w_state_nxt == ST_SLEEP)) begin
            r_sleep_cnt <= '0;
        end else if ((r_state == ST_SLEEP) && (r_sleep_cnt != {CNT_W{1'b1}})) begin
            r_sleep_cnt <= r_sleep_cnt + 1'b1;
        end
    end

    assign w_sleep_cnt = r_sleep_cnt;
`else
    assign w_sleep_cnt = {CNT_W{1'b0}};
`endif

    assign sleep_bus.o_clk_en     = r_clk_en;
    assign sleep_bus.o_sleeping   = r_sleeping;
    assign sleep_bus.o_abort      = r_abort;
    assign sleep_bus.o_wake_cause = r_wake_cause;
    assign sleep_bus.o_sleep_cnt  = w_sleep_cnt;

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// Directed-vector bench for servant_sleep_ctrl (DRAIN_MAX=8, WAKE_DELAY=4, CNT_W=4).
// Sleep-count expectations follow SERVANT_SLEEP_CNT_EN as seen by this compilation.
module tb_servant_sleep_ctrl;

    localparam int DRAIN_MAX  = 8;
    localparam int WAKE_DELAY = 4;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic rst;
    int   vecCount = 0;
    int   missCount = 0;

    servant_sleep_ctrl_if #(.CNT_W(CNT_W)) sleepBus ();

    servant_sleep_ctrl #(
        .DRAIN_MAX  (DRAIN_MAX),
        .WAKE_DELAY (WAKE_DELAY),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .sleep_bus (sleepBus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expCnt(input int n);
`ifdef SERVANT_SLEEP_CNT_EN
        expCnt = (n > ((1 << CNT_W) - 1)) ? 32'((1 << CNT_W) - 1) : 32'(n);
`else
        expCnt = 32'(n) & 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge take them, then settle 1ns past the edge.
    task automatic applyStimulus(input logic r, input logic sleep, input logic wakeup,
                                 input logic ext, input logic busy);
        rst                   = r;
        sleepBus.i_sleep_req  = sleep;
        sleepBus.i_wakeup_req = wakeup;
        sleepBus.i_ext_irq    = ext;
        sleepBus.i_wb_busy    = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_clk_en",   32'(sleepBus.o_clk_en), 1);
        checkOutput("rst_sleeping", 32'(sleepBus.o_sleeping), 0);
        checkOutput("rst_abort",    32'(sleepBus.o_abort), 0);
        checkOutput("rst_cause",    32'(sleepBus.o_wake_cause), 0);
        checkOutput("rst_cnt",      32'(sleepBus.o_sleep_cnt), 0);
        idleCycles(1);

        // Basic sleep / timer wake
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("basic_drain_clk_en", 32'(sleepBus.o_clk_en), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("basic_gate_clk_en",  32'(sleepBus.o_clk_en), 0);
        checkOutput("basic_gate_sleeping", 32'(sleepBus.o_sleeping), 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("basic_mid_cnt", 32'(sleepBus.o_sleep_cnt), expCnt(10));
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("basic_cause", 32'(sleepBus.o_wake_cause), 32'd1);
        idleCycles(3);
        checkOutput("basic_wake_clk_en", 32'(sleepBus.o_clk_en), 0);
        idleCycles(1);
        checkOutput("basic_run_clk_en",  32'(sleepBus.o_clk_en), 1);
        checkOutput("basic_run_sleeping", 32'(sleepBus.o_sleeping), 0);
        checkOutput("basic_cnt", 32'(sleepBus.o_sleep_cnt), expCnt(11));

        // Drain wait: busy for 3 cycles
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("drain_busy_clk_en", 32'(sleepBus.o_clk_en), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("drain_done_sleeping", 32'(sleepBus.o_sleeping), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("drain_cause", 32'(sleepBus.o_wake_cause), 32'd1);
        idleCycles(4);
        checkOutput("drain_run_clk_en", 32'(sleepBus.o_clk_en), 1);
        checkOutput("drain_cnt", 32'(sleepBus.o_sleep_cnt), expCnt(1));

        // Drain timeout: busy held high
        applyStimulus(0, 1, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1, 0, 0, 1);
            checkOutput("timeout_clk_en", 32'(sleepBus.o_clk_en), 1);
            checkOutput("timeout_abort_early", 32'(sleepBus.o_abort), 0);
        end
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("timeout_abort", 32'(sleepBus.o_abort), 1);
        checkOutput("timeout_abort_clk_en", 32'(sleepBus.o_clk_en), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("timeout_abort_drop", 32'(sleepBus.o_abort), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("timeout_stays_run", 32'(sleepBus.o_sleeping), 0);

        // Wake already high at the sleep edge
        idleCycles(1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("race_abort", 32'(sleepBus.o_abort), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("race_abort_drop", 32'(sleepBus.o_abort), 0);
        checkOutput("race_sleeping_a", 32'(sleepBus.o_sleeping), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("race_sleeping_b", 32'(sleepBus.o_sleeping), 0);

        // Wake arrives during DRAIN
        idleCycles(1);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("drainwake_pre_abort", 32'(sleepBus.o_abort), 0);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("drainwake_abort", 32'(sleepBus.o_abort), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("drainwake_abort_drop", 32'(sleepBus.o_abort), 0);
        checkOutput("drainwake_sleeping", 32'(sleepBus.o_sleeping), 0);

        // External IRQ wake through the synchroniser
        idleCycles(1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("ext_sleeping", 32'(sleepBus.o_sleeping), 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("ext_sync_cause", 32'(sleepBus.o_wake_cause), 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("ext_cause", 32'(sleepBus.o_wake_cause), 32'd2);
        idleCycles(3);
        checkOutput("ext_wake_clk_en", 32'(sleepBus.o_clk_en), 0);
        idleCycles(1);
        checkOutput("ext_run_clk_en", 32'(sleepBus.o_clk_en), 1);
        checkOutput("ext_cnt", 32'(sleepBus.o_sleep_cnt), expCnt(6));

        // Timer and external IRQ together
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("both_pre_cause", 32'(sleepBus.o_wake_cause), 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("both_cause", 32'(sleepBus.o_wake_cause), 32'd3);
        idleCycles(4);
        checkOutput("both_run_clk_en", 32'(sleepBus.o_clk_en), 1);
        checkOutput("both_cause_held", 32'(sleepBus.o_wake_cause), 32'd3);

        // Reset mid-SLEEP with the request held high
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rsleep_pre_sleeping", 32'(sleepBus.o_sleeping), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("rsleep_clk_en",   32'(sleepBus.o_clk_en), 1);
        checkOutput("rsleep_sleeping", 32'(sleepBus.o_sleeping), 0);
        checkOutput("rsleep_abort",    32'(sleepBus.o_abort), 0);
        checkOutput("rsleep_cnt",      32'(sleepBus.o_sleep_cnt), 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rsleep_held_no_sleep", 32'(sleepBus.o_sleeping), 0);
        checkOutput("rsleep_held_clk_en",   32'(sleepBus.o_clk_en), 1);

        // Reset mid-WAKE
        idleCycles(1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("rwake_pre_cause", 32'(sleepBus.o_wake_cause), 32'd1);
        idleCycles(1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rwake_clk_en",   32'(sleepBus.o_clk_en), 1);
        checkOutput("rwake_sleeping", 32'(sleepBus.o_sleeping), 0);
        checkOutput("rwake_cause",    32'(sleepBus.o_wake_cause), 0);
        checkOutput("rwake_cnt",      32'(sleepBus.o_sleep_cnt), 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rwake_resleep", 32'(sleepBus.o_sleeping), 1);
        applyStimulus(0, 1, 1, 0, 0);
        idleCycles(4);
        checkOutput("rwake_run_clk_en", 32'(sleepBus.o_clk_en), 1);
        checkOutput("rwake_run_cnt", 32'(sleepBus.o_sleep_cnt), expCnt(1));

        // Counter saturation over 20 SLEEP cycles
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("sat_mid_cnt", 32'(sleepBus.o_sleep_cnt), expCnt(14));
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        idleCycles(4);
        checkOutput("sat_cnt", 32'(sleepBus.o_sleep_cnt), expCnt(20));
        checkOutput("sat_run_clk_en", 32'(sleepBus.o_clk_en), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
